rdback_serializer: RTL and testbench

//  Drains the 4*DQ_WIDTH-bit readback FIFO in softMC's top level.

---
 rtl/rdback_serializer.sv | 162 ++++++++++++++++
 tb/tb_rdback_serializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdback_serializer.sv
// Readback FIFO drain for the host link.
// Pulls one 4*DQ_WIDTH-bit entry at a time from the readback FIFO and emits it
// as NBEATS OUT_WIDTH-bit beats, least significant slice first, on a
// valid/ready stream. A transfer of xfer_len entries is armed by xfer_start.
// The final beat of the transfer carries tx_last, and xfer_done pulses once
// in the following cycle.
module rdback_serializer #(
  parameter int TCQ       = 100,
  parameter int DQ_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    xfer_start,
  input  logic [LEN_WIDTH-1:0]    xfer_len,
  output logic                    xfer_busy,
  output logic                    xfer_done,
  output logic [LEN_WIDTH-1:0]    entries_sent,
  input  logic                    rdback_fifo_empty,
  output logic                    rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]   rdback_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [OUT_WIDTH-1:0]    tx_data,
  output logic                    tx_last
);

  localparam int ENTRY_W = 4 * DQ_WIDTH;
  localparam int NBEATS  = ENTRY_W / OUT_WIDTH;
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [LEN_WIDTH-1:0] ONE_LEFT  = LEN_WIDTH'(1);

  // Elaboration-time sanity checks on the parameter set.
  if ((ENTRY_W % OUT_WIDTH) != 0) begin : g_bad_out_width
    $error("OUT_WIDTH must divide 4*DQ_WIDTH");
  end
  if (TCQ < 0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [ENTRY_W-1:0]   shreg;
  logic [BEAT_W-1:0]    beat;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 done_q;
  logic                 handshake;
  logic                 entry_end;

  assign handshake = tx_valid & tx_ready;
  assign entry_end = handshake & (beat == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic plus the handshake-facing strobes.
  always_comb begin
    state_nx         = state;
    rdback_fifo_rden = 1'b0;
    tx_valid         = 1'b0;
    case (state)
      IDLE: begin
        if (xfer_start && (xfer_len != '0)) begin
          state_nx = FETCH;
        end
      end
      FETCH: begin
        // Gated with rst so a reset held across FETCH never pops the FIFO.
        if (!rdback_fifo_empty && !rst) begin
          rdback_fifo_rden = 1'b1;
          state_nx         = LOAD;
        end
      end
      LOAD: begin
        state_nx = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && (beat == LAST_BEAT)) begin
          state_nx = (remaining == ONE_LEFT) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Shift register, beat/entry counters and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      beat         <= '0;
      remaining    <= '0;
      entries_sent <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_start) begin
            remaining    <= xfer_len;
            entries_sent <= '0;
            // A zero-length transfer completes without ever leaving IDLE.
            if (xfer_len == '0) begin
              done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          shreg <= rdback_data;
          beat  <= '0;
        end
        SEND: begin
          if (handshake) begin
            shreg <= shreg >> OUT_WIDTH;
            beat  <= beat + 1'b1;
          end
          if (entry_end) begin
            beat         <= '0;
            entries_sent <= entries_sent + 1'b1;
            remaining    <= remaining - 1'b1;
            if (remaining == ONE_LEFT) begin
              done_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Busy covers every state that still owns the FIFO or the stream.
  always_comb begin
    xfer_busy = (state == FETCH) || (state == LOAD) || (state == SEND);
  end

  assign xfer_done = done_q;
  assign tx_data   = shreg[OUT_WIDTH-1:0];
  assign tx_last   = tx_valid & (beat == LAST_BEAT) & (remaining == ONE_LEFT);

endmodule

// File: tb/tb_rdback_serializer.sv
// Self-checking bench for rdback_serializer: a queue-based FIFO model feeds
// the DUT, and a beat scoreboard built from whole entries predicts the stream.
module tb_rdback_serializer;

  localparam int DQ_W  = 64;
  localparam int OUT_W = 32;
  localparam int LEN_W = 16;
  localparam int ENT_W = 4 * DQ_W;
  localparam int NB    = ENT_W / OUT_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             xfer_start;
  logic [LEN_W-1:0] xfer_len;
  logic             xfer_busy;
  logic             xfer_done;
  logic [LEN_W-1:0] entries_sent;
  logic             rdback_fifo_empty = 1'b1;
  logic             rdback_fifo_rden;
  logic [ENT_W-1:0] rdback_data = '0;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic [OUT_W-1:0] tx_data;
  logic             tx_last;

  logic [ENT_W-1:0] fifo_q[$];
  beat_t            exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rden_cnt = 0, valid_cnt = 0, done_cnt = 0;
  int rden_base = 0, valid_base = 0, done_base = 0;
  int start_cyc = 0, done_cyc = -1, last_cyc = -1;
  bit rand_ready  = 1'b0;
  bit ready_fixed = 1'b1;

  bit               stalled = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic             held_last;

  rdback_serializer #(
    .TCQ      (100),
    .DQ_WIDTH (DQ_W),
    .OUT_WIDTH(OUT_W),
    .LEN_WIDTH(LEN_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .xfer_start       (xfer_start),
    .xfer_len         (xfer_len),
    .xfer_busy        (xfer_busy),
    .xfer_done        (xfer_done),
    .entries_sent     (entries_sent),
    .rdback_fifo_empty(rdback_fifo_empty),
    .rdback_fifo_rden (rdback_fifo_rden),
    .rdback_data      (rdback_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .tx_last          (tx_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [ENT_W-1:0] got, input logic [ENT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle counter and FIFO model: standard read, data valid the cycle after rden.
  always @(posedge clk) begin
    logic [ENT_W-1:0] d;
    cyc <= cyc + 1;
    if (rdback_fifo_rden && fifo_q.size() > 0) begin
      d = fifo_q.pop_front();
      rdback_data <= d;
    end
    rdback_fifo_empty <= (fifo_q.size() == 0);
  end

  // Host-side ready: either fixed or a coin flip every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Stream monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (rdback_fifo_rden) begin
        rden_cnt++;
        check_eq("rden_while_empty", rdback_fifo_empty, 1'b0);
      end
      if (stalled) begin
        check_eq("hold_valid", tx_valid, 1'b1);
        check_eq("hold_data", tx_data, held_data);
        check_eq("hold_last", tx_last, held_last);
      end
      stalled = 1'b0;
      if (tx_valid) begin
        valid_cnt++;
        if (tx_ready) begin
          check_eq("beat_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check_eq("tx_data", tx_data, b.data);
            check_eq("tx_last", tx_last, b.last);
          end
          if (tx_last) last_cyc = cyc;
        end else begin
          stalled   = 1'b1;
          held_data = tx_data;
          held_last = tx_last;
        end
      end
      if (xfer_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_entry(input logic [ENT_W-1:0] d, input bit final_entry);
    beat_t b;
    fifo_q.push_back(d);
    for (int unsigned k = 0; k < NB; k++) begin
      b.data = OUT_W'(d >> (k * OUT_W));
      b.last = final_entry && (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [ENT_W-1:0] rand_entry();
    logic [ENT_W-1:0] e;
    for (int unsigned k = 0; k < ENT_W / 32; k++) e[k*32 +: 32] = $urandom;
    return e;
  endfunction

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push_entry(rand_entry(), i == n - 1);
  endtask

  task automatic start_xfer(input int len);
    @(posedge clk);
    #1;
    xfer_start = 1'b1;
    xfer_len   = LEN_W'(len);
    start_cyc  = cyc;
    done_base  = done_cnt;
    rden_base  = rden_cnt;
    valid_base = valid_cnt;
    @(posedge clk);
    #1;
    xfer_start = 1'b0;
    xfer_len   = LEN_W'($urandom);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != done_base) break;
    end
    check_eq(tag, done_cnt != done_base, 1'b1);
  endtask

  task automatic finish_xfer(input int len, input string tag);
    repeat (3) @(negedge clk);
    check_eq({tag, "_entries_sent"}, entries_sent, LEN_W'(len));
    check_eq({tag, "_rden_count"}, rden_cnt - rden_base, len);
    check_eq({tag, "_done_count"}, done_cnt - done_base, 1);
    check_eq({tag, "_beats_left"}, exp_q.size(), 0);
    check_eq({tag, "_busy_after"}, xfer_busy, 1'b0);
    check_eq({tag, "_valid_after"}, tx_valid, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, tx_valid, 1'b0);
    check_eq({tag, "_last"}, tx_last, 1'b0);
    check_eq({tag, "_data"}, tx_data, '0);
    check_eq({tag, "_busy"}, xfer_busy, 1'b0);
    check_eq({tag, "_done"}, xfer_done, 1'b0);
    check_eq({tag, "_rden"}, rdback_fifo_rden, 1'b0);
    check_eq({tag, "_entries"}, entries_sent, '0);
  endtask

  initial begin
    logic [ENT_W-1:0] e;
    int               d0;
    int               r0;
    int               len;
    rst        = 1'b1;
    xfer_start = 1'b0;
    xfer_len   = '0;

    // Power-on reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset held 3 cycles while stalled in SEND aborts without done.
    ready_fixed = 1'b0;
    push_random(2);
    start_xfer(2);
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
    check_eq("t1_reached_send", tx_valid, 1'b1);
    d0 = done_cnt;
    r0 = rden_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t1_after_rst");
    repeat (20) @(negedge clk);
    check_eq("t1_no_done", done_cnt, d0);
    check_eq("t1_no_rden", rden_cnt, r0);
    check_eq("t1_fifo_untouched", fifo_q.size(), 1);
    fifo_q.delete();
    exp_q.delete();
    ready_fixed = 1'b1;
    repeat (2) @(negedge clk);

    // Single entry, word i = i, full-rate ready.
    for (int unsigned i = 0; i < NB; i++) e[i*OUT_W +: OUT_W] = OUT_W'(i);
    push_entry(e, 1'b1);
    start_xfer(1);
    wait_done(100, "t2_done_seen");
    check_eq("t2_done_after_last", done_cyc - last_cyc, 1);
    finish_xfer(1, "t2");

    // Three entries with random backpressure.
    rand_ready = 1'b1;
    push_random(3);
    start_xfer(3);
    wait_done(2000, "t3_done_seen");
    finish_xfer(3, "t3");

    // FIFO empty for 50 cycles: FSM must wait in FETCH without reading.
    rand_ready = 1'b0;
    start_xfer(2);
    repeat (50) @(negedge clk);
    check_eq("t4_no_rden_while_empty", rden_cnt - rden_base, 0);
    check_eq("t4_busy_waiting", xfer_busy, 1'b1);
    check_eq("t4_no_valid_waiting", tx_valid, 1'b0);
    push_random(2);
    wait_done(200, "t4_done_seen");
    finish_xfer(2, "t4");

    // Zero-length transfer: done next cycle, nothing else moves.
    start_xfer(0);
    wait_done(5, "t5_done_seen");
    check_eq("t5_done_timing", done_cyc, start_cyc + 1);
    repeat (3) @(negedge clk);
    check_eq("t5_no_rden", rden_cnt - rden_base, 0);
    check_eq("t5_no_valid", valid_cnt - valid_base, 0);
    check_eq("t5_done_count", done_cnt - done_base, 1);
    check_eq("t5_entries_sent", entries_sent, '0);

    // Restart attempt mid-transfer is ignored.
    rand_ready = 1'b1;
    push_random(5);
    start_xfer(5);
    repeat (6) @(negedge clk);
    check_eq("t6_busy_mid", xfer_busy, 1'b1);
    @(posedge clk);
    #1;
    xfer_start = 1'b1;
    xfer_len   = LEN_W'(2);
    @(posedge clk);
    #1 xfer_start = 1'b0;
    wait_done(3000, "t6_done_seen");
    finish_xfer(5, "t6");

    // A few random transfers back to back.
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 6);
      push_random(len);
      start_xfer(len);
      wait_done(4000, "t7_done_seen");
      finish_xfer(len, "t7");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
